// File: rtl/data_memory_lsu.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_lsu
// Brief    : Handshaked little-endian word RAM with RISC-V load/store sizing,
//            access error detection, programmable latency and post-reset clear.
// Revision : 1.0
// ============================================================================
module data_memory_lsu #(
   parameter int DEPTH_WORDS    = 1024,
   parameter int READ_LATENCY   = 1,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic        i_req_we,
   input  logic [2:0]  i_req_funct3,
   input  logic [31:0] i_req_addr,
   input  logic [31:0] i_req_wdata,
   output logic        o_resp_valid,
   input  logic        i_resp_ready,
   output logic [31:0] o_resp_rdata,
   output logic        o_resp_error,
   output logic        o_init_done
);

   localparam int              c_AW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [32:0]     c_BYTES  = 33'(DEPTH_WORDS) << 2;
   localparam logic [1:0]      c_LAT_M1 = 2'(READ_LATENCY - 1);
   localparam logic [c_AW-1:0] c_LAST   = c_AW'(DEPTH_WORDS - 1);

   typedef enum logic [1:0] {
      S_INIT = 2'd0,
      S_IDLE = 2'd1,
      S_WAIT = 2'd2,
      S_RESP = 2'd3
   } state_t;

   localparam state_t c_RST_STATE = CLEAR_ON_RESET ? S_INIT : S_IDLE;

   state_t            r_state;
   state_t            w_next;
   logic [31:0]       r_mem [DEPTH_WORDS];
   logic [c_AW-1:0]   r_clr_cnt;
   logic [1:0]        r_lat_cnt;
   logic [31:0]       r_rdata;
   logic              r_error;
   logic              r_init_done;

   logic              w_req_ready;
   logic              w_resp_valid;
   logic              w_accept;
   logic [c_AW-1:0]   w_idx;
   logic [1:0]        w_lane;
   logic              w_illegal;
   logic              w_misal;
   logic              w_oor;
   logic              w_err;
   logic [31:0]       w_word;
   logic [7:0]        w_byte;
   logic [15:0]       w_half;
   logic [31:0]       w_load;
   logic [3:0]        w_be;
   logic [31:0]       w_wdata;
   logic              w_store;
   logic              w_clr_wr;

   assign w_idx    = i_req_addr[c_AW+1:2];
   assign w_lane   = i_req_addr[1:0];
   assign w_accept = i_req_valid && w_req_ready;
   assign w_clr_wr = (r_state == S_INIT) && !i_reset;

   // Error classification; any one of these turns the access into a no-op.
   always_comb begin
      w_illegal = i_req_we ? (i_req_funct3 > 3'd2)
                           : ((i_req_funct3[1:0] == 2'b11) || (i_req_funct3[2:1] == 2'b11));
      w_misal   = ((i_req_funct3[1:0] == 2'b01) && i_req_addr[0]) ||
                  ((i_req_funct3[1:0] == 2'b10) && (i_req_addr[1:0] != 2'b00));
      w_oor     = ({1'b0, i_req_addr} >= c_BYTES);
      w_err     = w_illegal || w_misal || w_oor;
   end

   always_comb begin
      w_word = r_mem[w_idx];
      w_byte = w_word[{w_lane, 3'b000} +: 8];
      w_half = w_word[{w_lane[1], 4'b0000} +: 16];
      case (i_req_funct3)
         3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
         3'b001:  w_load = {{16{w_half[15]}}, w_half};
         3'b010:  w_load = w_word;
         3'b100:  w_load = {24'd0, w_byte};
         3'b101:  w_load = {16'd0, w_half};
         default: w_load = 32'd0;
      endcase
   end

   // Store data is replicated across lanes so the enables alone pick the target bytes.
   always_comb begin
      case (i_req_funct3[1:0])
         2'b00: begin
            w_be    = 4'b0001 << w_lane;
            w_wdata = {4{i_req_wdata[7:0]}};
         end
         2'b01: begin
            w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{i_req_wdata[15:0]}};
         end
         default: begin
            w_be    = 4'b1111;
            w_wdata = i_req_wdata;
         end
      endcase
      w_store = w_accept && i_req_we && !w_err;
   end

   always_ff @(posedge i_clock) begin
      if (w_clr_wr) begin
         r_mem[r_clr_cnt] <= 32'd0;
      end else if (w_store) begin
         for (int b = 0; b < 4; b++) begin
            if (w_be[b]) begin
               r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state <= c_RST_STATE;
      end else begin
         r_state <= w_next;
      end
   end

   // In IDLE the ready is masked by reset so nothing is accepted while it is held.
   always_comb begin
      w_next       = r_state;
      w_req_ready  = 1'b0;
      w_resp_valid = 1'b0;
      case (r_state)
         S_INIT: begin
            if (r_clr_cnt == c_LAST) begin
               w_next = S_IDLE;
            end
         end
         S_IDLE: begin
            w_req_ready = !i_reset;
            if (i_req_valid && !i_reset) begin
               w_next = (READ_LATENCY == 1) ? S_RESP : S_WAIT;
            end
         end
         S_WAIT: begin
            if (r_lat_cnt <= 2'd1) begin
               w_next = S_RESP;
            end
         end
         S_RESP: begin
            w_resp_valid = 1'b1;
            if (i_resp_ready) begin
               w_next = S_IDLE;
            end
         end
         default: w_next = c_RST_STATE;
      endcase
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_clr_cnt   <= '0;
         r_lat_cnt   <= 2'd0;
         r_rdata     <= 32'd0;
         r_error     <= 1'b0;
         r_init_done <= !CLEAR_ON_RESET;
      end else begin
         case (r_state)
            S_INIT: begin
               r_clr_cnt <= r_clr_cnt + c_AW'(1);
               if (r_clr_cnt == c_LAST) begin
                  r_init_done <= 1'b1;
               end
            end
            S_IDLE: begin
               if (w_accept) begin
                  r_rdata   <= (w_err || i_req_we) ? 32'd0 : w_load;
                  r_error   <= w_err;
                  r_lat_cnt <= c_LAT_M1;
               end
            end
            S_WAIT: begin
               r_lat_cnt <= r_lat_cnt - 2'd1;
            end
            default: ;
         endcase
      end
   end

   assign o_req_ready  = w_req_ready;
   assign o_resp_valid = w_resp_valid;
   assign o_resp_rdata = r_rdata;
   assign o_resp_error = r_error;
   assign o_init_done  = r_init_done;

endmodule
`default_nettype wire

// File: tb/tb_data_memory_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_memory_lsu
// Brief    : Directed and randomized checks of data_memory_lsu against a
//            byte-array reference model.
// Revision : 1.0
// ============================================================================
module tb_data_memory_lsu;

   localparam int DEPTH = 16;
   localparam int LAT   = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'd0;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic        resp_valid;
   logic        resp_ready = 1'b1;
   logic [31:0] resp_rdata;
   logic        resp_error;
   logic        init_done;

   int n_checks = 0;
   int n_errors = 0;
   logic [7:0] ref_mem [0:DEPTH*4-1];

   always #5 clk = ~clk;

   data_memory_lsu #(
      .DEPTH_WORDS    (DEPTH),
      .READ_LATENCY   (LAT),
      .CLEAR_ON_RESET (1'b1)
   ) u_dut (
      .i_clock      (clk),
      .i_reset      (rst),
      .i_req_valid  (req_valid),
      .o_req_ready  (req_ready),
      .i_req_we     (req_we),
      .i_req_funct3 (req_funct3),
      .i_req_addr   (req_addr),
      .i_req_wdata  (req_wdata),
      .o_resp_valid (resp_valid),
      .i_resp_ready (resp_ready),
      .o_resp_rdata (resp_rdata),
      .o_resp_error (resp_error),
      .o_init_done  (init_done)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Byte-level model: applies stores to ref_mem and returns the expected response.
   function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wd, output logic [31:0] rd, output logic er);
      int          nb;
      logic        illegal;
      logic        mis;
      logic        oor;
      logic [31:0] v;
      illegal = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 >= 3'd6);
      nb      = 1 << f3[1:0];
      mis     = (nb == 2 && addr % 2 != 0) || (nb == 4 && addr % 4 != 0);
      oor     = addr >= 32'(DEPTH * 4);
      er      = illegal || mis || oor;
      rd      = 32'd0;
      if (er) return;
      if (we) begin
         for (int i = 0; i < nb; i++) ref_mem[addr + i] = wd[8*i +: 8];
      end else begin
         v = 32'd0;
         for (int i = 0; i < nb; i++) v = v | (32'(ref_mem[addr + i]) << (8 * i));
         if (f3[2] == 1'b0 && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8 * nb)) - 32'd1);
         rd = v;
      end
   endfunction

   task automatic clear_model();
      for (int i = 0; i < DEPTH * 4; i++) ref_mem[i] = 8'h00;
   endtask

   task automatic wait_init(input string tag);
      int cnt;
      cnt = 0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         cnt++;
         if (init_done) break;
      end
      check({tag, " init_cycles"}, 32'(cnt), 32'(DEPTH));
      check({tag, " ready_after_init"}, {31'd0, req_ready}, 32'd1);
   endtask

   task automatic do_txn(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd, input int hold);
      logic [31:0] erd;
      logic        eer;
      int          lat;
      bit          ok;
      model(we, f3, addr, wd, erd, eer);
      @(negedge clk);
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wd;
      req_valid  = 1'b1;
      resp_ready = (hold == 0);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (req_ready) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) begin
         check({tag, " accept_timeout"}, 32'd0, 32'd1);
         req_valid  = 1'b0;
         resp_ready = 1'b1;
         return;
      end
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 0;
      ok  = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         lat++;
         if (resp_valid) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         check({tag, " resp_timeout"}, 32'd0, 32'd1);
         resp_ready = 1'b1;
         return;
      end
      check({tag, " latency"}, 32'(lat), 32'(LAT));
      check({tag, " rdata"}, resp_rdata, erd);
      check({tag, " error"}, {31'd0, resp_error}, {31'd0, eer});
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check({tag, " hold_valid"}, {31'd0, resp_valid}, 32'd1);
         check({tag, " hold_ready"}, {31'd0, req_ready}, 32'd0);
         check({tag, " hold_rdata"}, resp_rdata, erd);
         check({tag, " hold_error"}, {31'd0, resp_error}, {31'd0, eer});
      end
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] a;
      logic        w;
      logic [2:0]  f;
      int          hold;
      bit          ok;

      repeat (3) @(negedge clk);
      check("rst req_ready", {31'd0, req_ready}, 32'd0);
      check("rst resp_valid", {31'd0, resp_valid}, 32'd0);
      check("rst resp_rdata", resp_rdata, 32'd0);
      check("rst resp_error", {31'd0, resp_error}, 32'd0);
      check("rst init_done", {31'd0, init_done}, 32'd0);
      rst = 1'b0;
      wait_init("boot");
      clear_model();

      do_txn("lw_3c", 1'b0, 3'b010, 32'h3C, 32'd0, 0);
      do_txn("sw_0", 1'b1, 3'b010, 32'h0, 32'h8081A2B3, 0);
      do_txn("lb_0", 1'b0, 3'b000, 32'h0, 32'd0, 0);
      do_txn("lbu_1", 1'b0, 3'b100, 32'h1, 32'd0, 0);
      do_txn("lh_2", 1'b0, 3'b001, 32'h2, 32'd0, 0);
      do_txn("lhu_2", 1'b0, 3'b101, 32'h2, 32'd0, 0);
      do_txn("sw_4", 1'b1, 3'b010, 32'h4, 32'hFFFFFFFF, 0);
      do_txn("sb_5", 1'b1, 3'b000, 32'h5, 32'h00000012, 0);
      do_txn("sh_6", 1'b1, 3'b001, 32'h6, 32'h0000ABCD, 0);
      do_txn("lw_4", 1'b0, 3'b010, 32'h4, 32'd0, 0);
      do_txn("lw_4_hold", 1'b0, 3'b010, 32'h4, 32'd0, 5);

      do_txn("sw_8", 1'b1, 3'b010, 32'h8, 32'h11223344, 0);
      do_txn("lw_mis", 1'b0, 3'b010, 32'h2, 32'd0, 0);
      do_txn("sh_mis", 1'b1, 3'b001, 32'h1, 32'h0000FFFF, 0);
      do_txn("lb_oor", 1'b0, 3'b000, 32'h40, 32'd0, 0);
      do_txn("ld_f3_011", 1'b0, 3'b011, 32'h0, 32'd0, 0);
      do_txn("sw_f3_011", 1'b1, 3'b011, 32'h8, 32'hFFFFFFFF, 0);
      do_txn("lw_8", 1'b0, 3'b010, 32'h8, 32'd0, 0);

      for (int i = 0; i < 300; i++) begin
         w    = 1'($urandom_range(0, 1));
         f    = 3'($urandom_range(0, 7));
         a    = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, DEPTH * 4 + 7));
         hold = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 4) : 0;
         do_txn($sformatf("rnd%0d", i), w, f, a, $urandom, hold);
      end

      // Reset while a committed store's response is still in WAIT.
      @(negedge clk);
      check("pre_wait ready", {31'd0, req_ready}, 32'd1);
      req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h8; req_wdata = 32'hDEADBEEF;
      req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst_wait resp_valid", {31'd0, resp_valid}, 32'd0);
      check("rst_wait req_ready", {31'd0, req_ready}, 32'd0);
      check("rst_wait init_done", {31'd0, init_done}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      wait_init("rst_wait");
      clear_model();
      do_txn("lw_8_after_rst", 1'b0, 3'b010, 32'h8, 32'd0, 0);

      // Reset while a response is being presented.
      @(negedge clk);
      req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h3C;
      req_valid = 1'b1; resp_ready = 1'b0;
      @(posedge clk);
      #1 req_valid = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (resp_valid) begin
            ok = 1'b1;
            break;
         end
      end
      check("rst_resp reached", {31'd0, ok}, 32'd1);
      #2 rst = 1'b1;
      #1;
      check("rst_resp resp_valid", {31'd0, resp_valid}, 32'd0);
      check("rst_resp rdata", resp_rdata, 32'd0);
      resp_ready = 1'b1;

      // Reset partway through INIT restarts the sweep from word 0.
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      check("mid_init init_done", {31'd0, init_done}, 32'd0);
      rst = 1'b1;
      #1;
      check("rst_init req_ready", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      wait_init("rst_init");
      clear_model();
      do_txn("lw_0_final", 1'b0, 3'b010, 32'h0, 32'd0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/data_memory_lsu.md
Name: data_memory_lsu

Overview:
- Parametrised, handshaked successor to the single-cycle byte-addressed data memory.
- Word-organised little-endian RAM with byte write enables.
- Supports the RISC-V load/store widths LB/LH/LW/LBU/LHU/SB/SH/SW, with sign/zero extension.
- Detects misaligned, out-of-range and illegal-funct3 accesses; programmable response latency.
- Clears itself sequentially after reset; sits between the MEM stage and the memory array.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; must be a power of two; byte address space is DEPTH_WORDS*4.
- READ_LATENCY, 1, cycles from request accept to resp_valid; legal range 1..4.
- CLEAR_ON_RESET, 1, when 1 the INIT sweep zeroes every word after reset; when 0 INIT is skipped.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3 width/sign code
- req_addr  in  32  byte address
- req_wdata  in  32  store data; low bytes used for SB/SH
- resp_valid  out  1  response present
- resp_ready  in  1  consumer takes the response
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_error  out  1  access was misaligned, out of range or had an illegal funct3
- init_done  out  1  INIT sweep finished

Behaviour:
- Reset (asynchronous) forces these values:
  - state=INIT, or IDLE if CLEAR_ON_RESET=0
  - req_ready=0, resp_valid=0, resp_rdata=0, resp_error=0
  - init_done=CLEAR_ON_RESET?0:1
  - clear counter=0, latency counter=0
  - Memory array contents are not asynchronously reset.
- INIT:
  - One word is written to 0 per clock at address = clear counter.
  - Moves to IDLE after word DEPTH_WORDS-1 is written (DEPTH_WORDS cycles).
  - init_done is set on that transition; req_ready=0 throughout.
- IDLE:
  - req_ready=1.
  - Accept occurs when req_valid&&req_ready at a rising edge.
  - On accept: decode, perform the store or capture the read word, load the latency counter with READ_LATENCY-1, move to WAIT, or directly to RESP if READ_LATENCY=1.
- WAIT:
  - req_ready=0; counter decrements each cycle.
  - At 0, move to RESP.
- RESP:
  - resp_valid=1; resp_rdata and resp_error are held stable.
  - On resp_valid&&resp_ready, return to IDLE. The next request can be accepted the cycle after.
- Throughput: one transaction in flight; a response appears exactly READ_LATENCY cycles after the accept edge when resp_ready is held at 1.
- Decode and error rules:
  - word index = req_addr[31:2]; byte lane = req_addr[1:0].
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; funct3 011/110/111 is illegal.
  - Stores: 000 SB, 001 SH, 010 SW; any other funct3 is illegal.
  - Misaligned: a halfword with addr[0]=1, or a word with addr[1:0]!=0.
  - Out of range: req_addr >= DEPTH_WORDS*4.
  - Any of these sets resp_error=1, suppresses the write and forces resp_rdata=0. The transaction still completes and produces a response.
- Store: only the addressed byte lanes are written, on the accept edge.
  - SB writes lane addr[1:0] with wdata[7:0].
  - SH writes lanes {addr[1],0}..{addr[1],1} with wdata[15:0].
  - SW writes all four lanes.
  - A store response carries rdata=0.
- Load:
  - The selected byte or halfword is shifted to bit 0.
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
  - The data returned is the memory state at the accept edge.
- Reset mid-INIT or mid-transaction: abort immediately.
  - An outstanding response is lost.
  - A store already committed at its accept edge stays in memory.
  - INIT restarts from word 0.
- resp_ready held low: the block stays in RESP indefinitely and req_ready stays 0.

Test Plan:
- Reset deasserted, DEPTH_WORDS=16 -> init_done rises after 16 cycles; LW from 0x3C returns 0x00000000 with no error.
- SW 0x0 data 0x8081A2B3; then LB 0x0 -> 0xFFFFFFB3; LBU 0x1 -> 0x000000A2; LH 0x2 -> 0xFFFF8081; LHU 0x2 -> 0x00008081.
- SW 0x4 0xFFFFFFFF; then SB 0x5 0x12, then SH 0x6 0xABCD; LW 0x4 -> 0xABCD12FF.
- READ_LATENCY=3, resp_ready=1 -> resp_valid exactly 3 cycles after accept; resp_ready held low for 5 cycles -> response held stable and req_ready=0.
- LW 0x2, SH 0x1, LB 0x40 with DEPTH_WORDS=16, funct3=011 load, SW 0x8 funct3=011 -> resp_error=1, rdata=0; a later LW of the store address shows it unchanged.
- Reset asserted while in WAIT and while in INIT -> resp_valid drops asynchronously and INIT restarts from word 0; a store committed before reset is observable via LW only if CLEAR_ON_RESET=0.
